uart_rx_data_path: RTL

Datapath stage paired with the UART receive control FSM. It synchronises the raw serial line and counts received bits for the FSM. It assembles each frame from the FSM's sample strobes, checks parity and the stop bit, then pushes byte plus error flags into a small first-word-fall-through FIFO. A valid/ready interface drains the FIFO to the consuming logic (register file or bus bridge).

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rx_fifo.sv | 50 +++++
 rtl/uart_rx_data_path.sv | 101 ++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants, the receive FIFO entry layout and the frame parity helper.
package uart_pkg;
    localparam int UART_DATA_W     = 8;
    localparam int UART_FRAME_BITS = 9;
    localparam int UART_BIT_CNT_W  = 4;
    localparam int UART_ENTRY_W    = UART_DATA_W + 2;
    localparam int ENTRY_PERR_BIT  = 8;
    localparam int ENTRY_FERR_BIT  = 9;

    // Field order puts data at [7:0], parity_err at [8] and frame_err at [9].
    typedef struct packed {
        logic                   frame_err;
        logic                   parity_err;
        logic [UART_DATA_W-1:0] data;
    } rx_entry_t;

    function automatic logic frame_parity_err(input logic [UART_FRAME_BITS-1:0] frame,
                                              input logic                       odd);
        return (^frame) ^ odd;
    endfunction
endpackage

// File: rtl/uart_rx_fifo.sv
// Generic synchronous first-word-fall-through FIFO; the head entry is always on pop_data.
module uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_eff;
    logic             pop_eff;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign pop_eff  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_eff = push && (!full || pop_eff);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_eff) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_eff) rd_ptr <= rd_ptr + 1'b1;
            case ({push_eff, pop_eff})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/uart_rx_data_path.sv
// UART receive datapath: line synchroniser, bit counter, frame shift register,
// parity/stop checking and FWFT frame queue with sticky overrun.
module uart_rx_data_path
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int PARITY_ODD  = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx_i,
    output logic                          rx_sync_o,
    input  logic                          sample_i,
    input  logic                          bit_count_enable_i,
    input  logic                          rst_bit_counter_i,
    input  logic                          enable_out_reg_i,
    output logic [UART_BIT_CNT_W-1:0]     Rx_bit_Count,
    output logic [UART_DATA_W-1:0]        rx_data_o,
    output logic                          parity_err_o,
    output logic                          frame_err_o,
    output logic                          rx_valid_o,
    input  logic                          rx_ready_i,
    output logic                          overrun_o,
    input  logic                          clr_overrun_i,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);
    localparam logic PARITY_ODD_BIT = (PARITY_ODD != 0);

    logic [SYNC_STAGES-1:0]     sync_q;
    logic [UART_FRAME_BITS-1:0] shift_q;
    rx_entry_t                  push_entry;
    rx_entry_t                  head_entry;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       drop;

    // Preset to 1 so the line looks idle out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync_q <= '1;
        else      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
    end
    assign rx_sync_o = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Rx_bit_Count <= '0;
        end else if (rst_bit_counter_i) begin
            Rx_bit_Count <= '0;
        end else if (bit_count_enable_i && (Rx_bit_Count != '1)) begin
            Rx_bit_Count <= Rx_bit_Count + 1'b1;
        end
    end

    // LSB arrives first, so after nine samples data sits in [7:0] and parity in [8].
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q <= '0;
        end else if (rst_bit_counter_i) begin
            shift_q <= '0;
        end else if (sample_i) begin
            shift_q <= {rx_sync_o, shift_q[UART_FRAME_BITS-1:1]};
        end
    end

    always_comb begin
        push_entry            = '0;
        push_entry.frame_err  = ~rx_sync_o;
        push_entry.parity_err = frame_parity_err(shift_q, PARITY_ODD_BIT);
        push_entry.data       = shift_q[UART_DATA_W-1:0];
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (enable_out_reg_i),
        .push_data (push_entry),
        .pop       (rx_ready_i),
        .pop_data  (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count_o)
    );

    // A full FIFO popped in the same cycle makes room, so only push-without-pop drops.
    assign drop = enable_out_reg_i && fifo_full && !rx_ready_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)               overrun_o <= 1'b0;
        else if (drop)          overrun_o <= 1'b1;
        else if (clr_overrun_i) overrun_o <= 1'b0;
    end

    assign rx_valid_o   = !fifo_empty;
    assign rx_data_o    = head_entry.data;
    assign parity_err_o = head_entry.parity_err;
    assign frame_err_o  = head_entry.frame_err;
endmodule
